// File: rtl/morse_msg_sequencer_if.sv
// Byte-source / ROM / encoder signal bundle for morse_msg_sequencer.
// The sent_cnt member exists only when CHAR_CNT_EN is defined.
interface morse_msg_sequencer_if;
   logic        in_vald;
   logic [7:0]  in_char;
   logic        fifo_full;
   logic        fifo_empty;
   logic        ovf;
   logic [7:0]  rom_addr;
   logic [11:0] rom_data;
   logic        char_vald;
   logic [7:0]  charcode_data;
   logic [3:0]  charlen_data;
   logic        char_next;
   logic        busy;
   logic        bad_char;
   logic        timeout;
`ifdef CHAR_CNT_EN
   logic [15:0] sent_cnt;
`endif

   // Sequencer side
   modport slave (
      input  in_vald, in_char, rom_data, char_next,
      output fifo_full, fifo_empty, ovf, rom_addr, char_vald,
      output charcode_data, charlen_data, busy, bad_char, timeout
`ifdef CHAR_CNT_EN
      , output sent_cnt
`endif
   );

   // Host / ROM / encoder side
   modport master (
      output in_vald, in_char, rom_data, char_next,
      input  fifo_full, fifo_empty, ovf, rom_addr, char_vald,
      input  charcode_data, charlen_data, busy, bad_char, timeout
`ifdef CHAR_CNT_EN
      , input sent_cnt
`endif
   );
endinterface

// File: rtl/morse_msg_sequencer.sv
// Message-level controller for the dassign3 Morse LED encoder.
// Buffers ASCII bytes in a FIFO, looks each byte up in an external
// synchronous ASCII-to-Morse ROM and hands one character at a time to the
// encoder over the char_vald/char_next handshake.
// Optional feature macro: CHAR_CNT_EN (adds the 16-bit sent_cnt output).
module morse_msg_sequencer #(
   parameter int DEPTH   = 16,
   parameter int SETTLE  = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                 clock,
   input  logic                 reset,
   morse_msg_sequencer_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
   localparam logic [7:0]    WAIT_LAST   = 8'(TIMEOUT - 1);
   localparam logic [AW:0]   FULL_COUNT  = (AW + 1)'(DEPTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_LOOKUP = 3'd2;
   localparam logic [2:0] S_ISSUE  = 3'd3;
   localparam logic [2:0] S_WAIT   = 3'd4;
   localparam logic [2:0] S_SETTLE = 3'd5;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          fifo_full_q, fifo_full_d;
   logic          fifo_empty_q, fifo_empty_d;
   logic          ovf_q, ovf_d;
   logic [2:0]    state_q, state_d;
   logic [7:0]    rom_addr_q, rom_addr_d;
   logic [7:0]    code_q, code_d;
   logic [3:0]    len_q, len_d;
   logic          char_vald_q, char_vald_d;
   logic          char_next_q, char_next_d;
   logic [7:0]    wait_cnt_q, wait_cnt_d;
   logic [SW-1:0] settle_cnt_q, settle_cnt_d;
   logic          busy_q, busy_d;
   logic          bad_char_q, bad_char_d;
   logic          timeout_q, timeout_d;
`ifdef CHAR_CNT_EN
   logic [15:0]   sent_cnt_q, sent_cnt_d;
`endif

   logic push;
   logic pop;
   logic done;

   // Handshake qualifiers: accepted push, FSM pop, encoder rising edge
   always_comb begin
      push = bus.in_vald & ~fifo_full_q;
      pop  = (state_q == S_IDLE) & ~fifo_empty_q;
      done = bus.char_next & ~char_next_q;
   end

   // FIFO pointers, occupancy, status flags and sticky overflow
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (bus.in_vald && fifo_full_q) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
      fifo_full_d  = (count_d == FULL_COUNT);
      fifo_empty_d = (count_d == {(AW + 1){1'b0}});
   end

   // Character sequencing FSM: fetch, ROM lookup, issue, wait, settle
   always_comb begin
      state_d      = state_q;
      rom_addr_d   = rom_addr_q;
      code_d       = code_q;
      len_d        = len_q;
      char_vald_d  = 1'b0;
      wait_cnt_d   = wait_cnt_q;
      settle_cnt_d = settle_cnt_q;
      bad_char_d   = bad_char_q;
      timeout_d    = timeout_q;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty_q) begin
               state_d    = S_FETCH;
               rom_addr_d = mem_q[rd_ptr_q];
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            state_d = S_LOOKUP;
         end
         S_LOOKUP: begin
            if (bus.rom_data[3:0] > 4'd8) begin
               bad_char_d = 1'b1;
               state_d    = S_IDLE;
            end else begin
               code_d      = bus.rom_data[11:4];
               len_d       = bus.rom_data[3:0];
               char_vald_d = 1'b1;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wait_cnt_d = 8'd0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            if (done) begin
               settle_cnt_d = {SW{1'b0}};
               state_d      = S_SETTLE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               timeout_d    = 1'b1;
               settle_cnt_d = {SW{1'b0}};
               state_d      = S_SETTLE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_SETTLE: begin
            if (settle_cnt_q == SETTLE_LAST) begin
               state_d = S_IDLE;
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
               state_d      = S_SETTLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d      = (state_d != S_IDLE);
      char_next_d = bus.char_next;
   end

`ifdef CHAR_CNT_EN
   // Issued-character counter; one count per ISSUE cycle, wraps naturally
   always_comb begin
      if (state_q == S_ISSUE) begin
         sent_cnt_d = sent_cnt_q + 16'd1;
      end else begin
         sent_cnt_d = sent_cnt_q;
      end
   end
`endif

   // FIFO storage; contents need no reset because the pointers define validity
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.in_char;
      end
   end

   // Control and output registers with asynchronous clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q     <= {AW{1'b0}};
         rd_ptr_q     <= {AW{1'b0}};
         count_q      <= {(AW + 1){1'b0}};
         fifo_full_q  <= 1'b0;
         fifo_empty_q <= 1'b1;
         ovf_q        <= 1'b0;
         state_q      <= S_IDLE;
         rom_addr_q   <= 8'h00;
         code_q       <= 8'h00;
         len_q        <= 4'h0;
         char_vald_q  <= 1'b0;
         char_next_q  <= 1'b0;
         wait_cnt_q   <= 8'd0;
         settle_cnt_q <= {SW{1'b0}};
         busy_q       <= 1'b0;
         bad_char_q   <= 1'b0;
         timeout_q    <= 1'b0;
`ifdef CHAR_CNT_EN
         sent_cnt_q   <= 16'd0;
`endif
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         fifo_full_q  <= fifo_full_d;
         fifo_empty_q <= fifo_empty_d;
         ovf_q        <= ovf_d;
         state_q      <= state_d;
         rom_addr_q   <= rom_addr_d;
         code_q       <= code_d;
         len_q        <= len_d;
         char_vald_q  <= char_vald_d;
         char_next_q  <= char_next_d;
         wait_cnt_q   <= wait_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         busy_q       <= busy_d;
         bad_char_q   <= bad_char_d;
         timeout_q    <= timeout_d;
`ifdef CHAR_CNT_EN
         sent_cnt_q   <= sent_cnt_d;
`endif
      end
   end

   assign bus.fifo_full     = fifo_full_q;
   assign bus.fifo_empty    = fifo_empty_q;
   assign bus.ovf           = ovf_q;
   assign bus.rom_addr      = rom_addr_q;
   assign bus.char_vald     = char_vald_q;
   assign bus.charcode_data = code_q;
   assign bus.charlen_data  = len_q;
   assign bus.busy          = busy_q;
   assign bus.bad_char      = bad_char_q;
   assign bus.timeout       = timeout_q;
`ifdef CHAR_CNT_EN
   assign bus.sent_cnt      = sent_cnt_q;
`endif

endmodule

// File: tb/tb_morse_msg_sequencer.sv
// Self-checking bench for morse_msg_sequencer: Morse ROM model, dassign3-like
// encoder model, directed scenarios and randomized byte streams.
module tb_morse_msg_sequencer;
   localparam int DEPTH   = 16;
   localparam int SETTLE  = 2;
   localparam int TIMEOUT = 255;

   typedef logic [7:0] byteq_t[$];
   typedef struct {
      logic [7:0] code;
      logic [3:0] len;
      int         cyc;
      logic       rdy;
   } rec_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   morse_msg_sequencer_if bus();

   morse_msg_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clock) cyc <= cyc + 1;

   string morse_az [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                            ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                            "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
   string morse_09 [10] = '{"-----", ".----", "..---", "...--", "....-",
                            ".....", "-....", "--...", "---..", "----."};

   // Reference ROM contents: real Morse for A-Z/0-9, space = word gap,
   // 0x7F = corrupt entry, everything else a synthetic valid pattern.
   function automatic logic [11:0] rom_fn(input logic [7:0] a);
      string      s;
      logic [7:0] code;
      int         n;
      code = 8'h00;
      if (a == 8'h7F) return 12'hFFF;
      if (a == 8'h20) return 12'h000;
      if (a >= 8'h41 && a <= 8'h5A) s = morse_az[int'(a) - 65];
      else if (a >= 8'h30 && a <= 8'h39) s = morse_09[int'(a) - 48];
      else return {a ^ 8'h5A, 4'(int'(a) % 9)};
      n = s.len();
      for (int i = 0; i < n; i++) if (s[i] == 8'h2D) code[7 - i] = 1'b1;
      return {code, 4'(n)};
   endfunction

   function automatic byteq_t str2q(input string s);
      byteq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   // Synchronous ROM: data one cycle after address
   always @(posedge clock) bus.rom_data <= rom_fn(bus.rom_addr);

   // Encoder model: ready high when idle, drops on char_vald, rises enc_delay later
   rec_t       log_q[$];
   int         enc_delay = 3;
   logic       enc_stall = 1'b0;
   int         enc_cnt   = 0;
   int         rise_cyc  = 0;
   int         wide_cnt  = 0;
   int         stab_viol = 0;
   logic       prev_vald = 1'b0;
   logic [7:0] hold_code = 8'h00;
   logic [3:0] hold_len  = 4'h0;

   always @(negedge clock) begin
      if (reset) begin
         bus.char_next = 1'b1;
         enc_cnt       = 0;
         prev_vald     = 1'b0;
         hold_code     = 8'h00;
         hold_len      = 4'h0;
      end else begin
         if (bus.char_vald && prev_vald) wide_cnt++;
         if (!bus.char_next && !enc_stall &&
             (bus.charcode_data !== hold_code || bus.charlen_data !== hold_len)) stab_viol++;
         prev_vald = bus.char_vald;
         if (bus.char_vald) begin
            log_q.push_back('{bus.charcode_data, bus.charlen_data, cyc, bus.char_next});
            hold_code     = bus.charcode_data;
            hold_len      = bus.charlen_data;
            bus.char_next = 1'b0;
            enc_cnt       = enc_delay;
         end else if (!bus.char_next && !enc_stall) begin
            if (enc_cnt <= 0) begin
               bus.char_next = 1'b1;
               rise_cyc      = cyc;
            end else begin
               enc_cnt--;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_seq(input byteq_t b, input int gap_max);
      foreach (b[i]) begin
         @(negedge clock);
         bus.in_vald = 1'b1;
         bus.in_char = b[i];
         if (gap_max > 0) begin
            int g;
            g = $urandom_range(gap_max, 0);
            repeat (g) begin
               @(negedge clock);
               bus.in_vald = 1'b0;
            end
         end
      end
      @(negedge clock);
      bus.in_vald = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k;
      k = 0;
      while ((bus.busy || !bus.fifo_empty || bus.char_next !== 1'b1) && k < budget) begin
         @(negedge clock);
         k++;
      end
      chk(tag, 32'(k < budget), 32'd1);
   endtask

   task automatic wait_log(input string tag, input int base, input int budget);
      int k;
      k = 0;
      while (log_q.size() <= base && k < budget) begin
         @(negedge clock);
         k++;
      end
      chk(tag, 32'(log_q.size() > base), 32'd1);
   endtask

   // Expected issue order = pushed bytes with corrupt ROM entries skipped
   task automatic check_log(input string tag, input int base, input byteq_t src, input logic chk_rdy);
      logic [11:0] e[$];
      logic [11:0] r;
      int          got;
      foreach (src[i]) begin
         r = rom_fn(src[i]);
         if (r[3:0] <= 4'd8) e.push_back(r);
      end
      got = log_q.size() - base;
      chk({tag, "_count"}, 32'(got), 32'(e.size()));
      for (int i = 0; i < e.size() && i < got; i++) begin
         r = e[i];
         chk($sformatf("%s_code%0d", tag, i), 32'(log_q[base + i].code), 32'(r[11:4]));
         chk($sformatf("%s_len%0d", tag, i), 32'(log_q[base + i].len), 32'(r[3:0]));
         if (chk_rdy) chk($sformatf("%s_rdy%0d", tag, i), 32'(log_q[base + i].rdy), 32'd1);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int     base, c0, v, k, stab0, rst_base;
      logic   any_bad;
      byteq_t q;

      bus.in_vald = 1'b0;
      bus.in_char = 8'h00;
      #1 reset = 1'b1;
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      rst_base = log_q.size();

      // Reset state
      chk("rst_empty", 32'(bus.fifo_empty), 32'd1);
      chk("rst_full", 32'(bus.fifo_full), 32'd0);
      chk("rst_ovf", 32'(bus.ovf), 32'd0);
      chk("rst_vald", 32'(bus.char_vald), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_bad", 32'(bus.bad_char), 32'd0);
      chk("rst_tmo", 32'(bus.timeout), 32'd0);
      chk("rst_addr", 32'(bus.rom_addr), 32'd0);
      chk("rst_code", 32'(bus.charcode_data), 32'd0);
      chk("rst_len", 32'(bus.charlen_data), 32'd0);

      // Single 'M': latency, contents, busy fall after SETTLE
      base = log_q.size();
      @(negedge clock);
      c0 = cyc;
      bus.in_vald = 1'b1;
      bus.in_char = 8'h4D;
      @(negedge clock);
      bus.in_vald = 1'b0;
      wait_log("m_seen", base, 20);
      if (log_q.size() > base) begin
         chk("m_latency", 32'(log_q[base].cyc), 32'(c0 + 4));
         chk("m_code", 32'(log_q[base].code), 32'hC0);
         chk("m_len", 32'(log_q[base].len), 32'd2);
      end
      k = 0;
      while (bus.busy && k < 100) begin
         @(negedge clock);
         k++;
      end
      chk("m_busy_fall", 32'(cyc), 32'(rise_cyc + SETTLE + 1));

      // String "M16 TA" back-to-back
      base  = log_q.size();
      stab0 = stab_viol;
      push_seq(str2q("M16 TA"), 0);
      wait_idle("str_idle", 500);
      check_log("str", base, str2q("M16 TA"), 1'b1);
      chk("str_stable", 32'(stab_viol - stab0), 32'd0);

      // Overflow with stalled encoder, then timeout on the first byte
      enc_stall = 1'b1;
      base = log_q.size();
      push_seq(str2q("ABCDEFGHIJKLMNOPQZ"), 0);
      chk("ovf_full", 32'(bus.fifo_full), 32'd1);
      chk("ovf_flag", 32'(bus.ovf), 32'd1);
      wait_log("ovf_first", base, 20);
      v = (log_q.size() > base) ? log_q[base].cyc : cyc;
      k = 0;
      while (cyc < v + TIMEOUT && k < 400) begin
         @(negedge clock);
         k++;
      end
      chk("tmo_before", 32'(bus.timeout), 32'd0);
      @(negedge clock);
      chk("tmo_at", 32'(bus.timeout), 32'd1);
      enc_stall = 1'b0;
      wait_idle("ovf_drain", 8000);
      check_log("ovf", base, str2q("ABCDEFGHIJKLMNOPQ"), 1'b0);

      // Corrupt ROM entry skipped, next byte issued
      base = log_q.size();
      q = {};
      q.push_back(8'h7F);
      q.push_back(8'h4B);
      push_seq(q, 0);
      wait_idle("bad_idle", 500);
      chk("bad_flag", 32'(bus.bad_char), 32'd1);
      check_log("bad", base, q, 1'b1);

      // Asynchronous reset while waiting on the encoder
      enc_delay = 30;
      base = log_q.size();
      push_seq(str2q("TAB"), 0);
      wait_log("mid_seen", base, 20);
      repeat (4) @(negedge clock);
      chk("mid_busy", 32'(bus.busy), 32'd1);
      chk("mid_empty", 32'(bus.fifo_empty), 32'd0);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk("ar_vald", 32'(bus.char_vald), 32'd0);
      chk("ar_busy", 32'(bus.busy), 32'd0);
      chk("ar_empty", 32'(bus.fifo_empty), 32'd1);
      chk("ar_sticky", 32'({bus.ovf, bus.bad_char, bus.timeout}), 32'd0);
      @(posedge clock);
      #2 reset = 1'b0;
      enc_delay = 3;
      rst_base = log_q.size();
      base = log_q.size();
      push_seq(str2q("E"), 0);
      wait_idle("e_idle", 500);
      check_log("e", base, str2q("E"), 1'b1);

      // Randomized streams against the reference model
      any_bad = 1'b0;
      for (int r = 0; r < 6; r++) begin
         int n;
         q = {};
         n = $urandom_range(12, 1);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(7, 0) == 0) q.push_back(8'h7F);
            else q.push_back(8'($urandom_range(8'h7E, 8'h20)));
            if (q[i] == 8'h7F) any_bad = 1'b1;
         end
         enc_delay = $urandom_range(12, 0);
         base  = log_q.size();
         stab0 = stab_viol;
         push_seq(q, 3);
         wait_idle($sformatf("rnd%0d_idle", r), 3000);
         check_log($sformatf("rnd%0d", r), base, q, 1'b1);
         chk($sformatf("rnd%0d_stable", r), 32'(stab_viol - stab0), 32'd0);
      end
      chk("rnd_bad_flag", 32'(bus.bad_char), 32'(any_bad));
      chk("rnd_tmo_clear", 32'(bus.timeout), 32'd0);
`ifdef CHAR_CNT_EN
      chk("sent_cnt", 32'(bus.sent_cnt), 32'(log_q.size() - rst_base));
`endif
      chk("pulse_width", 32'(wide_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
